// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response channel and the decode-facing instruction port.
// master = fetch stage, slave = memory + decode side.
interface if_prefetch_queue_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [AW-1:0]   imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] Instruction;
    logic [AW-1:0]   pc_current;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, Instruction, pc_current,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, Instruction, pc_current,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: in-order imem fetches with credit-based flow control into a
// prefetch queue of {pc, word}; taken branches flush the queue and drop in-flight responses.
module if_prefetch_queue #(
    parameter int            XLEN     = 32,
    parameter int            AW       = 32,
    parameter int            DEPTH    = 4,
    parameter int            MAX_OUT  = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 IsBranchTaken,
    input  logic [AW-1:0]        BranchPC,
    if_prefetch_queue_if.master  bus
);
    localparam int STRIDE = XLEN / 8;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int QC_W   = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int SUM_W  = ((QC_W > CNT_W) ? QC_W : CNT_W) + 1;

    localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(STRIDE - 1));
    localparam logic [AW-1:0] RESET_ALN  = RESET_PC & ALIGN_MASK;

    logic [AW-1:0]    fetch_pc;
    logic [AW-1:0]    rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] out_nxt;
    logic [QC_W-1:0]  q_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [XLEN-1:0]  q_data [DEPTH];
    logic [AW-1:0]    q_pc   [DEPTH];

    logic [SUM_W-1:0] in_flight;
    logic             req_valid;
    logic             req_fire;
    logic             rsp_take;
    logic             enq;
    logic             deq;
    logic             head_valid;

    // Entries already queued plus responses still owed that will actually be kept.
    assign in_flight = SUM_W'(q_count) + SUM_W'(outstanding) - SUM_W'(drop_cnt);

    assign req_valid  = Rst_n && !IsBranchTaken && (outstanding < CNT_W'(MAX_OUT))
                        && (in_flight < SUM_W'(DEPTH));
    assign req_fire   = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding can only be left over from before reset.
    assign rsp_take   = bus.imem_rsp_valid && (outstanding != '0);
    assign enq        = rsp_take && (drop_cnt == '0) && !IsBranchTaken;
    assign head_valid = (q_count != '0);
    assign deq        = head_valid && bus.inst_ready && !IsBranchTaken;
    assign out_nxt    = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = head_valid;
    assign bus.Instruction    = head_valid ? q_data[rd_ptr] : '0;
    assign bus.pc_current     = head_valid ? q_pc[rd_ptr]   : '0;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            fetch_pc    <= RESET_ALN;
            rsp_pc      <= RESET_ALN;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_count     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= out_nxt;
            if (IsBranchTaken) begin
                fetch_pc <= BranchPC & ALIGN_MASK;
                rsp_pc   <= BranchPC & ALIGN_MASK;
                drop_cnt <= out_nxt;
                q_count  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + AW'(STRIDE);
                end
                if (rsp_take && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                if (enq) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    rsp_pc <= rsp_pc + AW'(STRIDE);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                q_count <= q_count + QC_W'(enq) - QC_W'(deq);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n && enq) begin
            q_data[wr_ptr] <= bus.imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: in-order memory model with configurable latency, epoch-tagged
// requests so stale responses are recognised, and a scoreboard of expected {pc, word} pops.
module tb_if_prefetch_queue;
    localparam int XLEN    = 32;
    localparam int AW      = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        is_branch;
    logic [31:0] branch_pc;

    always #5 clk = ~clk;

    if_prefetch_queue_if #(.XLEN(XLEN), .AW(AW)) bus ();

    if_prefetch_queue #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)
    ) dut (
        .Clk(clk),
        .Rst_n(rst_n),
        .IsBranchTaken(is_branch),
        .BranchPC(branch_pc),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] target;
        logic [31:0] exp_addr;
    } redir_vec_t;

    req_t        pend[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          ready_mode = 0;
    logic        inst_rdy_drv = 1'b1;
    logic [31:0] exp_fetch = 32'h0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        popped = 1'b0;
    logic [31:0] last_pop_pc = 32'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, observe 1ns later, return just after the posedge.
    task automatic step();
        exp_t e;
        req_t r;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memfn(r.addr);
            if (r.epoch == epoch && !is_branch && rst_n)
                sb.push_back('{r.addr, memfn(r.addr)});
        end
        bus.imem_req_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.inst_ready     = inst_rdy_drv;
        #1;
        popped = 1'b0;
        if (is_branch || !rst_n) begin
            check("req_valid_blocked", 64'(bus.imem_req_valid), 64'd0);
            sb.delete();
            epoch++;
            exp_fetch  = rst_n ? (branch_pc & ~32'h3) : 32'h0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("req_held_valid", 64'(bus.imem_req_valid), 64'd1);
                check("req_held_addr", 64'(bus.imem_req_addr), 64'(prev_addr));
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", 64'(bus.imem_req_addr), 64'(exp_fetch));
                pend.push_back('{bus.imem_req_addr, cyc + lat, epoch});
                exp_fetch = exp_fetch + 32'd4;
            end
            prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
            prev_addr  = bus.imem_req_addr;
            if (bus.inst_valid && bus.inst_ready) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", 64'(bus.pc_current), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("pop_pc", 64'(bus.pc_current), 64'(e.pc));
                    check("pop_instr", 64'(bus.Instruction), 64'(e.data));
                end
                popped      = 1'b1;
                last_pop_pc = bus.pc_current;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(input string name);
        int n = 0;
        step();
        while (!popped && n < 20) begin
            step();
            n++;
        end
        if (!popped) check(name, 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        redir_vec_t vecs[4];
        int          gaps;
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        logic [31:0] wrap_exp[2];

        vecs[0] = '{2, 32'h0000_0100, 32'h0000_0100};
        vecs[1] = '{2, 32'h0000_0103, 32'h0000_0100};
        vecs[2] = '{1, 32'h0000_2002, 32'h0000_2000};
        vecs[3] = '{1, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        wrap_exp[0] = 32'hFFFF_FFFC;
        wrap_exp[1] = 32'h0000_0000;

        rst_n              = 1'b0;
        is_branch          = 1'b0;
        branch_pc          = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b1;

        step();
        step();
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_instruction", 64'(bus.Instruction), 64'd0);
        check("rst_pc_current", 64'(bus.pc_current), 64'd0);

        // Streaming with 1-cycle memory: one pop per cycle once the pipe is full.
        rst_n = 1'b1;
        check("first_req_addr", 64'(bus.imem_req_addr), 64'd0);
        for (int i = 0; i < 3; i++) step();
        gaps = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (!popped) gaps++;
        end
        check("stream_gaps", 64'(gaps), 64'd0);

        // Backpressure: head frozen, fetch stops once the queue is full.
        inst_rdy_drv = 1'b0;
        held_pc      = 32'h0;
        held_instr   = 32'h0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 4) begin
                held_pc    = bus.pc_current;
                held_instr = bus.Instruction;
            end else if (i > 4) begin
                check("bp_hold_pc", 64'(bus.pc_current), 64'(held_pc));
                check("bp_hold_instr", 64'(bus.Instruction), 64'(held_instr));
            end
        end
        check("bp_req_stopped", 64'(bus.imem_req_valid), 64'd0);
        check("bp_inst_valid", 64'(bus.inst_valid), 64'd1);
        check("bp_sb_full", 64'(sb.size()), 64'(DEPTH));
        if (sb.size() > 0) check("bp_head_pc", 64'(bus.pc_current), 64'(sb[0].pc));
        inst_rdy_drv = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Redirect vectors, including misaligned target and the top-of-address-space wrap.
        foreach (vecs[k]) begin
            lat = vecs[k].lat;
            for (int i = 0; i < 6; i++) step();
            is_branch = 1'b1;
            branch_pc = vecs[k].target;
            step();
            is_branch = 1'b0;
            check("redir_inst_valid", 64'(bus.inst_valid), 64'd0);
            check("redir_req_addr", 64'(bus.imem_req_addr), 64'(vecs[k].exp_addr));
            wait_pop("redir_timeout");
            check("redir_first_pc", 64'(last_pop_pc), 64'(vecs[k].exp_addr));
        end
        foreach (wrap_exp[k]) begin
            wait_pop("wrap_timeout");
            check("wrap_pc", 64'(last_pop_pc), 64'(wrap_exp[k]));
        end

        // Back-to-back redirects: only the last target survives.
        lat = 2;
        for (int i = 0; i < 4; i++) step();
        is_branch = 1'b1;
        branch_pc = 32'h0000_0400;
        step();
        branch_pc = 32'h0000_0800;
        step();
        is_branch = 1'b0;
        wait_pop("b2b_timeout");
        check("b2b_first_pc", 64'(last_pop_pc), 64'h800);

        // Random memory stalls and decode backpressure.
        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            inst_rdy_drv = 1'($urandom_range(0, 1));
            step();
        end
        ready_mode   = 0;
        inst_rdy_drv = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Reset mid-stream with responses in flight and entries queued.
        lat          = 2;
        inst_rdy_drv = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        step();
        check("midrst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("midrst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        for (int i = 0; i < 3; i++) step();
        rst_n        = 1'b1;
        inst_rdy_drv = 1'b1;
        check("midrst_req_addr", 64'(bus.imem_req_addr), 64'd0);
        wait_pop("midrst_timeout");
        check("midrst_first_pc", 64'(last_pop_pc), 64'd0);
        for (int i = 0; i < 6; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
